// File: rtl/mmio_io_bridge.sv
// Bridges a streaming producer/consumer pair onto the CPU's memory-mapped I/O words.
// The input side is a FIFO that the CPU pops by a snooped write; the output side captures on rising output_ready.
module mmio_io_bridge #(
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4,
  parameter logic [11:0] MMIO_BASE = 12'h800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bus_addr,
  input  logic [31:0] bus_data,
  input  logic        bus_wr_en,
  input  logic [31:0] ext_in_data,
  input  logic        ext_in_valid,
  output logic        ext_in_ready,
  output logic [31:0] input_data,
  output logic [31:0] input_ready,
  input  logic [31:0] output_data,
  input  logic [31:0] output_ready,
  output logic [31:0] ext_out_data,
  output logic        ext_out_valid,
  input  logic        ext_out_ready,
  output logic        out_drop
);

  localparam int unsigned DW  = 32;
  localparam int unsigned IAW = $clog2(IN_DEPTH);
  localparam int unsigned OAW = $clog2(OUT_DEPTH);
  localparam int unsigned IPW = IAW + 1;
  localparam int unsigned OPW = OAW + 1;
  localparam logic [11:0] POP_ADDR = MMIO_BASE + 12'd4;

  // Input FIFO
  logic [DW-1:0]  in_mem [IN_DEPTH];
  logic [IAW:0]   in_wr_ptr, in_rd_ptr, in_wr_nxt, in_rd_nxt;
  logic           in_empty, in_full_nxt, in_push, in_pop;

  assign in_empty = (in_wr_ptr == in_rd_ptr);
  assign in_push  = ext_in_valid & ext_in_ready;
  assign in_pop   = bus_wr_en && (bus_addr == POP_ADDR) && !bus_data[0] && !in_empty;
  assign in_wr_nxt = in_wr_ptr + IPW'(in_push);
  assign in_rd_nxt = in_rd_ptr + IPW'(in_pop);
  assign in_full_nxt = (in_wr_nxt[IAW] != in_rd_nxt[IAW]) &&
                       (in_wr_nxt[IAW-1:0] == in_rd_nxt[IAW-1:0]);

  // Ready reflects post-edge occupancy, so a pop only re-opens it one edge later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_wr_ptr    <= '0;
      in_rd_ptr    <= '0;
      ext_in_ready <= 1'b0;
    end else begin
      in_wr_ptr    <= in_wr_nxt;
      in_rd_ptr    <= in_rd_nxt;
      ext_in_ready <= !in_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && in_push) begin
      in_mem[in_wr_ptr[IAW-1:0]] <= ext_in_data;
    end
  end

  assign input_data  = in_empty ? '0 : in_mem[in_rd_ptr[IAW-1:0]];
  assign input_ready = {{(DW-1){1'b0}}, !in_empty};

  // Output FIFO
  logic [DW-1:0]  out_mem [OUT_DEPTH];
  logic [OAW:0]   out_wr_ptr, out_rd_ptr;
  logic           out_empty, out_full, out_push, out_pop, capture, prev_rdy;

  assign out_empty = (out_wr_ptr == out_rd_ptr);
  assign out_full  = (out_wr_ptr[OAW] != out_rd_ptr[OAW]) &&
                     (out_wr_ptr[OAW-1:0] == out_rd_ptr[OAW-1:0]);
  assign out_pop   = ext_out_valid & ext_out_ready;
  assign capture   = output_ready[0] & !prev_rdy;
  // A same-edge drain frees the slot the capture lands in
  assign out_push  = capture & (!out_full | out_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      prev_rdy   <= 1'b1;
      out_drop   <= 1'b0;
    end else begin
      out_wr_ptr <= out_wr_ptr + OPW'(out_push);
      out_rd_ptr <= out_rd_ptr + OPW'(out_pop);
      prev_rdy   <= output_ready[0];
      out_drop   <= out_drop | (capture & out_full & !out_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && out_push) begin
      out_mem[out_wr_ptr[OAW-1:0]] <= output_data;
    end
  end

  assign ext_out_valid = !out_empty;
  assign ext_out_data  = out_empty ? '0 : out_mem[out_rd_ptr[OAW-1:0]];

  logic unused_bits;
  assign unused_bits = ^{output_ready[31:1], bus_data[31:1]};

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Directed plus randomized-handshake bench for mmio_io_bridge with queue scoreboards on both FIFOs.
module tb_mmio_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_wr_en;
  logic [31:0] ext_in_data;
  logic        ext_in_valid;
  logic        ext_in_ready;
  logic [31:0] input_data;
  logic [31:0] input_ready;
  logic [31:0] output_data;
  logic [31:0] output_ready;
  logic [31:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic        out_drop;

  always #5 clk = ~clk;

  mmio_io_bridge #(.IN_DEPTH(4), .OUT_DEPTH(4), .MMIO_BASE(12'h800)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_addr     (bus_addr),
    .bus_data     (bus_data),
    .bus_wr_en    (bus_wr_en),
    .ext_in_data  (ext_in_data),
    .ext_in_valid (ext_in_valid),
    .ext_in_ready (ext_in_ready),
    .input_data   (input_data),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_ready (output_ready),
    .ext_out_data (ext_out_data),
    .ext_out_valid(ext_out_valid),
    .ext_out_ready(ext_out_ready),
    .out_drop     (out_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snoop(input logic [11:0] a, input logic [31:0] d);
    bus_addr = a; bus_data = d; bus_wr_en = 1'b1;
    tick();
    bus_wr_en = 1'b0;
  endtask

  task automatic push_in(input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    ext_in_data = d; ext_in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = ext_in_ready;
      tick();
    end
    ext_in_valid = 1'b0;
    chk("push_accept", 32'(acc), 32'd1);
    if (acc) in_q.push_back(d);
  endtask

  task automatic pop_in(input string tag);
    logic [31:0] want;
    want = (in_q.size() > 0) ? in_q.pop_front() : 32'h0;
    chk({tag, "_rdy"}, input_ready, 32'd1);
    chk(tag, input_data, want);
    snoop(12'h804, 32'h0);
  endtask

  task automatic pulse_out(input logic [31:0] d, input bit stored);
    output_data = d; output_ready = 32'd1;
    tick();
    output_ready = 32'd0;
    tick();
    if (stored) out_q.push_back(d);
  endtask

  task automatic drain_out(input string tag);
    logic [31:0] want;
    want = (out_q.size() > 0) ? out_q.pop_front() : 32'h0;
    chk({tag, "_vld"}, 32'(ext_out_valid), 32'd1);
    chk(tag, ext_out_data, want);
    ext_out_ready = 1'b1;
    tick();
    ext_out_ready = 1'b0;
  endtask

  initial begin
    int sent_in, got_in, sent_out, got_out;
    logic prev, do_pop;
    rst_n = 1'b0; bus_addr = '0; bus_data = '0; bus_wr_en = 1'b0;
    ext_in_data = '0; ext_in_valid = 1'b0; output_data = '0; output_ready = '0;
    ext_out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(ext_in_ready), 32'd0);
    chk("rst_input_ready", input_ready, 32'd0);
    chk("rst_input_data", input_data, 32'd0);
    chk("rst_out_valid", 32'(ext_out_valid), 32'd0);
    chk("rst_out_data", ext_out_data, 32'd0);
    chk("rst_out_drop", 32'(out_drop), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(ext_in_ready), 32'd1);

    // Single push then pop, with writes to other addresses in between
    push_in(32'hA5A5_0001);
    chk("push1_rdy", input_ready, 32'd1);
    chk("push1_data", input_data, 32'hA5A5_0001);
    snoop(12'h800, 32'h0);
    snoop(12'h808, 32'h0);
    snoop(12'h80C, 32'h0);
    snoop(12'h804, 32'h1);
    snoop(12'h004, 32'h0);
    chk("snoop_other_rdy", input_ready, 32'd1);
    chk("snoop_other_data", input_data, 32'hA5A5_0001);
    pop_in("pop1");
    chk("pop1_empty_rdy", input_ready, 32'd0);
    chk("pop1_empty_data", input_data, 32'd0);
    snoop(12'h804, 32'h0);
    chk("pop_empty_ignored", 32'(ext_in_ready), 32'd1);

    // Fill to full, hold the fifth word, free one slot
    for (int i = 1; i <= 4; i++) push_in(32'(i));
    chk("full_ready_low", 32'(ext_in_ready), 32'd0);
    ext_in_data = 32'd5; ext_in_valid = 1'b1;
    tick(); tick();
    chk("fifth_held", 32'(ext_in_ready), 32'd0);
    pop_in("full_pop");
    chk("ready_after_pop", 32'(ext_in_ready), 32'd1);
    tick();
    ext_in_valid = 1'b0;
    in_q.push_back(32'd5);
    chk("refull_ready_low", 32'(ext_in_ready), 32'd0);
    for (int i = 0; i < 4; i++) pop_in("order");
    chk("drained_in", input_ready, 32'd0);

    // Simultaneous push and pop
    push_in(32'd10);
    ext_in_data = 32'd11; ext_in_valid = 1'b1;
    bus_addr = 12'h804; bus_data = 32'h0; bus_wr_en = 1'b1;
    chk("simul_head", input_data, 32'd10);
    tick();
    ext_in_valid = 1'b0; bus_wr_en = 1'b0;
    void'(in_q.pop_front());
    in_q.push_back(32'd11);
    pop_in("simul_next");
    chk("simul_empty", input_ready, 32'd0);

    // Capture on rising edge only, held high for 10 cycles
    output_data = 32'h42; output_ready = 32'd1;
    tick();
    out_q.push_back(32'h42);
    chk("cap_valid", 32'(ext_out_valid), 32'd1);
    chk("cap_data", ext_out_data, 32'h42);
    for (int i = 0; i < 9; i++) tick();
    output_ready = 32'd0;
    tick();
    drain_out("cap_drain");
    chk("cap_once", 32'(ext_out_valid), 32'd0);

    // Overflow with consumer stalled
    for (int i = 1; i <= 5; i++) pulse_out(32'(i), i <= 4);
    chk("ovf_drop", 32'(out_drop), 32'd1);
    chk("ovf_stable", ext_out_data, 32'd1);
    for (int i = 0; i < 4; i++) drain_out("ovf_order");
    chk("ovf_empty", 32'(ext_out_valid), 32'd0);
    chk("drop_sticky", 32'(out_drop), 32'd1);

    // output_ready held across reset must not capture
    output_ready = 32'd1; output_data = 32'h99; rst_n = 1'b0;
    tick(); tick();
    chk("rst2_drop", 32'(out_drop), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("rst2_no_cap", 32'(ext_out_valid), 32'd0);
    output_ready = 32'd0;
    tick();
    output_data = 32'h77; output_ready = 32'd1;
    tick();
    out_q.push_back(32'h77);
    output_ready = 32'd0;
    drain_out("rst2_cap");
    chk("rst2_empty", 32'(ext_out_valid), 32'd0);

    // Random handshakes through both FIFOs
    sent_in = 0; got_in = 0; sent_out = 0; got_out = 0; prev = 1'b0;
    for (int cyc = 0; cyc < 3000 && !(got_in == 20 && got_out == 20); cyc++) begin
      ext_in_valid = (sent_in < 20) && ($urandom_range(0, 1) == 1);
      ext_in_data  = 32'h1000 + 32'(sent_in);
      do_pop = input_ready[0] && ($urandom_range(0, 1) == 1);
      bus_addr = 12'h804; bus_data = 32'h0; bus_wr_en = do_pop;
      if (do_pop) begin
        chk("rnd_in", input_data, (in_q.size() > 0) ? in_q.pop_front() : 32'hDEAD_BEEF);
        got_in++;
      end
      if (ext_in_valid && ext_in_ready) begin
        in_q.push_back(ext_in_data);
        sent_in++;
      end
      ext_out_ready = ($urandom_range(0, 1) == 1);
      if (ext_out_valid && ext_out_ready) begin
        chk("rnd_out", ext_out_data, (out_q.size() > 0) ? out_q.pop_front() : 32'hDEAD_BEEF);
        got_out++;
      end
      output_data  = 32'h2000 + 32'(sent_out);
      output_ready = 32'(!prev && sent_out < 20 && out_q.size() < 4 && $urandom_range(0, 1) == 1);
      if (output_ready[0] && !prev) begin
        out_q.push_back(output_data);
        sent_out++;
      end
      prev = output_ready[0];
      tick();
    end
    ext_in_valid = 1'b0; bus_wr_en = 1'b0; ext_out_ready = 1'b0; output_ready = 32'd0;
    tick();
    chk("rnd_in_count", 32'(got_in), 32'd20);
    chk("rnd_out_count", 32'(got_out), 32'd20);
    chk("rnd_in_empty", input_ready, 32'd0);
    chk("rnd_out_empty", 32'(ext_out_valid), 32'd0);
    chk("rnd_no_drop", 32'(out_drop), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_io_bridge.md
MMIO_IO_BRIDGE -- requirements
Module: mmio_io_bridge

Interface
REQ-001 SHALL have parameter IN_DEPTH, default 4, input FIFO depth in words; power of two, 2..16.
REQ-002 SHALL have parameter OUT_DEPTH, default 4, output FIFO depth in words; power of two, 2..16.
REQ-003 SHALL have parameter MMIO_BASE, default 12'h800, byte address of input_data; input_ready at +4, output_data at +8, output_ready at +12.
REQ-004 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port bus_addr  input  12  CPU data-bus byte address (snooped).
REQ-007 SHALL have port bus_data  input  32  CPU data-bus write data (snooped).
REQ-008 SHALL have port bus_wr_en  input  1  CPU data-bus write enable (snooped).
REQ-009 SHALL have port ext_in_data  input  32  word from external producer.
REQ-010 SHALL have port ext_in_valid  input  1  producer word valid.
REQ-011 SHALL have port ext_in_ready  output  1  bridge accepts ext_in_data.
REQ-012 SHALL have port input_data  output  32  word driven to data memory input_data.
REQ-013 SHALL have port input_ready  output  32  driven to data memory input_ready; bit0 = word available, bits 31:1 = 0.
REQ-014 SHALL have port output_data  input  32  from data memory output_data.
REQ-015 SHALL have port output_ready  input  32  from data memory output_ready; only bit0 used.
REQ-016 SHALL have port ext_out_data  output  32  word to external consumer.
REQ-017 SHALL have port ext_out_valid  output  1  ext_out_data valid.
REQ-018 SHALL have port ext_out_ready  input  1  consumer accepts.
REQ-019 SHALL have port out_drop  output  1  sticky: output word lost to full FIFO.

Function
REQ-020 Input accept SHALL occur on a posedge with ext_in_valid=1 and ext_in_ready=1; the word is pushed into the input FIFO.
REQ-021 ext_in_ready SHALL be registered, equal to 1 exactly when the input FIFO held fewer than IN_DEPTH words after the previous edge; a same-cycle pop SHALL NOT raise it.
REQ-022 input_data SHALL equal the input FIFO head when non-empty, else 32'h0; input_ready bit0 SHALL equal input FIFO non-empty; both combinational from registered FIFO state.
REQ-023 Pop SHALL occur on a posedge with bus_wr_en=1, bus_addr=MMIO_BASE+4, bus_data[0]=0 and input FIFO non-empty; pop on empty SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL both take effect; occupancy unchanged; head advances.
REQ-025 Output capture SHALL occur on a posedge where output_ready[0]=1 and a registered copy prev_rdy (previous cycle's output_ready[0]) =0; output_data at that edge is captured.
REQ-026 Captured word SHALL be pushed to the output FIFO unless full; a drain (ext_out_valid & ext_out_ready) on the same edge SHALL free the slot first, so capture then succeeds.
REQ-027 Capture with output FIFO full and no same-edge drain SHALL discard the word and set out_drop; out_drop SHALL clear only on reset.
REQ-028 ext_out_valid SHALL equal output FIFO non-empty; ext_out_data SHALL equal head, 32'h0 when empty; ext_out_data SHALL remain stable while ext_out_valid=1 and ext_out_ready=0.
REQ-029 Both FIFOs SHALL be circular with pointers of log2(DEPTH)+1 bits; full/empty from pointer MSB compare; wrap-around SHALL lose no word and preserve order.
REQ-030 Snooped writes to MMIO_BASE, MMIO_BASE+8, MMIO_BASE+12 and all other addresses SHALL NOT alter input FIFO state.
REQ-031 Latency: ext accept at edge N SHALL give input_ready[0]=1 after edge N (empty FIFO); capture at edge N SHALL give ext_out_valid=1 after edge N.

Reset
REQ-032 With rst_n=0 at a posedge, both FIFOs SHALL become empty, out_drop=0, ext_in_ready=0, ext_out_valid=0, input_ready=0, input_data=0, ext_out_data=0.
REQ-033 prev_rdy SHALL reset to 1, so output_ready[0] held high across reset release SHALL NOT capture; a fresh 0->1 is required.
REQ-034 ext_in_ready SHALL rise at the first posedge with rst_n=1; reset mid-transfer SHALL discard all buffered words, with no handshake completing on a reset edge.

Verification
REQ-035 Push 32'hA5A5_0001 via ext_in, then snooped write 0 to 0x804 -> input_data=32'hA5A5_0001, input_ready=1 after the push edge; both 0 after the pop edge.
REQ-036 Push 5 words with no pops (IN_DEPTH=4) -> ext_in_ready=0 after 4th accept; 5th held; one pop -> ready=1 next edge; 5th then accepted; order 1..5 preserved.
REQ-037 output_data=32'h0000_0042, output_ready 0->1 -> ext_out_valid=1, ext_out_data=32'h42; held 1 for 10 cycles -> exactly one word captured.
REQ-038 ext_out_ready=0, five 0->1 pulses with data 1..5 -> FIFO holds 1..4, out_drop=1; then drain -> 1,2,3,4 in order.
REQ-039 output_ready=1 through reset and release -> no capture; drop to 0 then 1 -> one capture.
REQ-040 Pointers wrap: 20 words streamed through each FIFO with random valid/ready -> all 20 delivered in order, no duplicates, out_drop=0.
